ets_sweep_ctrl: RTL and testbench
=================================

# ets_sweep_ctrl

Sequencer that drives the equivalent-time-sampling accumulator from the initiator side. It owns the accumulator's `start`/`done` handshake and the `enc` sample strobe, and steps a delay-tap phase index across a configured range. For each phase it collects the accumulated count and streams `{phase, count}` results out over a valid/ready interface to the host-facing logic.

## Interface
Parameters:
- `PHASE_W`, 6: width of the phase index (up to 64 phases).
- `DATA_W`, 32: width of the accumulator count.
- `SETTLE`, 4: cycles to wait after a phase change before asserting `ets_start`; must be ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sweep_start`  in  1  single-cycle request to begin a sweep; ignored while `busy`.
- `last_phase`  in  PHASE_W  final phase index, inclusive; latched when `sweep_start` is accepted.
- `enc_div`  in  8  strobe divider; latched when `sweep_start` is accepted.
- `phase`  out  PHASE_W  delay-tap select driven to the sampling front end.
- `enc`  out  1  sample-enable strobe to the accumulator.
- `ets_start`  out  1  accumulator start (level).
- `ets_done`  in  1  accumulator done (level).
- `ets_data`  in  DATA_W  accumulator count; valid while `ets_done` is high.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  DATA_W  captured count.
- `res_phase`  out  PHASE_W  phase index of the captured count.
- `res_last`  out  1  result belongs to the final phase.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sweep_done`  out  1  one-cycle pulse when the final result is accepted.

## Operation
The state machine has five states: IDLE, SETTLE, RUN, RELEASE and OUT. All outputs are decoded from registered state and registered data; there are no combinational paths from inputs to outputs.

- **IDLE**
  - On `sweep_start`: `phase`←0, latch `last_phase` and `enc_div`, `settle_cnt`←SETTLE-1, go to SETTLE.
- **SETTLE**
  - `ets_start`=0.
  - If `settle_cnt`==0, go to RUN; otherwise decrement `settle_cnt`.
  - The machine therefore spends exactly SETTLE cycles in this state.
- **RUN**
  - `ets_start`=1.
  - On `ets_done`=1, capture the result:
    - `res_data`←`ets_data`
    - `res_phase`←`phase`
    - `res_last`←(`phase`==latched last_phase)
  - Then go to RELEASE.
- **RELEASE**
  - `ets_start`=0.
  - Wait for `ets_done`=0, which lets the accumulator pass through its clear step, then go to OUT.
- **OUT**
  - `res_valid`=1.
  - On `res_ready`:
    - If `res_last`: pulse `sweep_done`, go to IDLE.
    - Otherwise: `phase`←`phase`+1, `settle_cnt`←SETTLE-1, go to SETTLE.

Other rules:
- **enc generation**
  - `enc_cnt` is held at 0 in IDLE.
  - While busy: `enc_cnt`←(`enc_cnt`==div) ? 0 : `enc_cnt`+1.
  - `enc`=`busy` & (`enc_cnt`==0).
  - `enc_div`=0 gives `enc` high continuously; `enc_div`=N gives one pulse every N+1 cycles.
- **Ignored inputs**
  - `ets_done` is ignored outside RUN and RELEASE.
  - `sweep_start` is ignored when not in IDLE.
- **Phase range**
  - `phase` never wraps, because the sweep terminates at `last_phase`.
  - `last_phase`=2^PHASE_W−1 is legal.
  - `last_phase`=0 yields exactly one result.
- **Result stability**
  - `res_data`, `res_phase` and `res_last` hold their values until the next capture.
  - They are stable for the whole time `res_valid` is high.

## Timing
- **Reset**
  - State←IDLE; `phase`, `enc_cnt`, `settle_cnt`, `res_data`, `res_phase`, `res_last`←0.
  - All outputs are 0.
  - Reset asserted mid-sweep drops `ets_start` immediately (asynchronously).
- **Sweep start latency**
  - `sweep_start` is sampled at edge 0, so `busy` goes high after edge 0.
  - `ets_start` rises after edge SETTLE.
- **Capture latency**
  - `ets_done` is sampled high at edge k.
  - After edge k, `ets_start` is 0 and the results are registered.
  - `res_valid` rises one cycle after `ets_done` is seen low.
  - Minimum latency from done to `res_valid` is 2 cycles.
- **Handshake**
  - A transfer occurs on any edge where `res_valid`&`res_ready` are both high.
  - `res_ready` held high means zero stall.
  - `res_valid` may wait indefinitely; holding `res_ready` low stalls the sweep without losing data.
- **Inter-phase gap**
  - After acceptance, `phase` updates on the accept edge.
  - `ets_start` reasserts SETTLE cycles later.
- **Sweep completion**
  - `sweep_done` is high for the one cycle after the final accept.
  - `busy` falls on that same edge.

## Test plan
1. **Single-phase sweep**
   - Stimulus: SETTLE=4, `last_phase`=0, accumulator model returns 0x1234 after 10 cycles of `ets_start`.
   - Required: exactly one result {0x1234, phase 0, last=1}; `sweep_done` pulses once; `ets_start` rises 4 cycles after `busy`.
2. **Four-phase sweep**
   - Stimulus: `last_phase`=3; model returns 100+phase; `res_ready` tied high.
   - Required: results 100, 101, 102, 103 with phases 0–3; only the last has `res_last`=1; `phase` output steps 0→3 and stops.
3. **Backpressure**
   - Stimulus: `res_ready` held low for 20 cycles on phase 1.
   - Required: `res_valid` and data stable for all 20 cycles; `ets_start` stays 0; no phase advance until accept.
4. **enc divider**
   - Stimulus: `enc_div`=3.
   - Required: `enc` pulses every 4th cycle while busy, the first pulse in the cycle after the sweep start edge; `enc` is 0 in IDLE.
   - Stimulus: `enc_div`=0.
   - Required: `enc` high continuously while busy.
5. **Sticky done**
   - Stimulus: the model holds `ets_done` high for 5 cycles after `ets_start` drops.
   - Required: a single capture; `res_valid` rises 1 cycle after done falls.
   - Stimulus: a spurious `ets_done` in SETTLE.
   - Required: it is ignored.
6. **Reset and ignored start**
   - Stimulus: `rst_n` asserted low during RUN of phase 2.
   - Required: all outputs 0 immediately.
   - Stimulus: after release, a `sweep_start` pulse.
   - Required: a fresh sweep from phase 0.
   - Stimulus: a second `sweep_start` while busy.
   - Required: it has no effect.

Source files
------------

// File: rtl/ets_sweep_ctrl.sv
// Steps a delay-tap phase across a range, runs one accumulator start/done cycle per phase, streams {phase,count} results.
// Results appear 2+ cycles after done; holding res_ready low parks the sweep in OUT with the result held stable.
module ets_sweep_ctrl #(
    parameter int PHASE_W = 6,
    parameter int DATA_W  = 32,
    parameter int SETTLE  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sweep_start,
    input  logic [PHASE_W-1:0] last_phase,
    input  logic [7:0]         enc_div,
    output logic [PHASE_W-1:0] phase,
    output logic               enc,
    output logic               ets_start,
    input  logic               ets_done,
    input  logic [DATA_W-1:0]  ets_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [PHASE_W-1:0] res_phase,
    output logic               res_last,
    output logic               busy,
    output logic               sweep_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [7:0]         enc_cnt;
    logic [7:0]         div_q;
    logic [PHASE_W-1:0] last_q;

    // Every output is a decode of registered state, so reset drops them asynchronously.
    assign busy      = (state != S_IDLE);
    assign ets_start = (state == S_RUN);
    assign res_valid = (state == S_OUT);
    assign enc       = busy & (enc_cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            settle_cnt <= '0;
            enc_cnt    <= '0;
            div_q      <= '0;
            last_q     <= '0;
            res_data   <= '0;
            res_phase  <= '0;
            res_last   <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;

            if (state == S_IDLE) begin
                enc_cnt <= 8'd0;
            end else begin
                enc_cnt <= (enc_cnt == div_q) ? 8'd0 : enc_cnt + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (sweep_start) begin
                        phase      <= '0;
                        last_q     <= last_phase;
                        div_q      <= enc_div;
                        settle_cnt <= SETTLE_INIT;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (ets_done) begin
                        res_data  <= ets_data;
                        res_phase <= phase;
                        res_last  <= (phase == last_q);
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Accumulator must drop done (its clear step) before the next start.
                    if (!ets_done) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (res_last) begin
                            sweep_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            phase      <= phase + PHASE_W'(1);
                            settle_cnt <= SETTLE_INIT;
                            state      <= S_SETTLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Directed bench for ets_sweep_ctrl with a small behavioural accumulator.
module tb_ets_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sweep_start = 1'b0;
    logic [5:0]  last_phase = '0;
    logic [7:0]  enc_div = '0;
    logic [5:0]  phase;
    logic        enc;
    logic        ets_start;
    logic        ets_done;
    logic [31:0] ets_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [5:0]  res_phase;
    logic        res_last;
    logic        busy;
    logic        sweep_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_data[$];
    logic [5:0]  q_phase[$];
    logic        q_last[$];
    int          done_cnt = 0;

    int          model_delay = 10;
    int          model_sticky = 0;
    logic [31:0] model_base = '0;
    int          acc_cnt = 0;
    int          hold_cnt = 0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;

    assign ets_done = model_done | spur_done;

    always #5 clk = ~clk;

    ets_sweep_ctrl #(.PHASE_W(6), .DATA_W(32), .SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .last_phase(last_phase),
        .enc_div(enc_div), .phase(phase), .enc(enc), .ets_start(ets_start),
        .ets_done(ets_done), .ets_data(ets_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_phase(res_phase),
        .res_last(res_last), .busy(busy), .sweep_done(sweep_done)
    );

    // Accumulator: done after model_delay cycles of start, held model_sticky cycles after start drops.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            model_done = 1'b0;
            acc_cnt    = 0;
            hold_cnt   = 0;
        end else if (ets_start) begin
            hold_cnt = 0;
            if (!model_done) begin
                acc_cnt++;
                if (acc_cnt >= model_delay) begin
                    model_done = 1'b1;
                    ets_data   = model_base + 32'(phase);
                end
            end
        end else begin
            acc_cnt = 0;
            if (model_done) begin
                if (hold_cnt >= model_sticky) begin
                    model_done = 1'b0;
                    hold_cnt   = 0;
                end else begin
                    hold_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                q_data.push_back(res_data);
                q_phase.push_back(res_phase);
                q_last.push_back(res_last);
            end
            if (sweep_done) done_cnt++;
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_phase.delete();
        q_last.delete();
        done_cnt = 0;
    endtask

    // Returns at the negedge right after the start edge.
    task automatic do_start(input logic [5:0] lp, input logic [7:0] div);
        @(negedge clk);
        last_phase  = lp;
        enc_div     = div;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, ets_start, res_valid, enc, sweep_done, res_last} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000000", {busy, ets_start, res_valid, enc, sweep_done, res_last});
        end
        n_cmp++; if (phase !== 6'd0 || res_phase !== 6'd0) begin
            n_bad++; $display("FAIL reset_phase: got %0d/%0d want 0/0", phase, res_phase);
        end
        n_cmp++; if (res_data !== 32'd0) begin
            n_bad++; $display("FAIL reset_data: got %0h want 0", res_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_phase();
        bit ok;
        clear_q();
        model_base = 32'h1234; model_delay = 10; model_sticky = 0;
        res_ready = 1'b1;
        do_start(6'd0, 8'd0);
        n_cmp++; if (busy !== 1'b1) begin
            n_bad++; $display("FAIL single_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ets_start !== 1'b0) begin
                n_bad++; $display("FAIL single_settle%0d: ets_start got %b want 0", i, ets_start);
            end
            @(negedge clk);
        end
        n_cmp++; if (ets_start !== 1'b1) begin
            n_bad++; $display("FAIL single_start_rise: got %b want 1", ets_start);
        end
        wait_done(200, ok);
        n_cmp++; if (!ok) begin
            n_bad++; $display("FAIL single_timeout: busy still 1 want 0");
        end
        n_cmp++; if (q_data.size() !== 1) begin
            n_bad++; $display("FAIL single_count: got %0d want 1", q_data.size());
        end
        n_cmp++; if (q_data[0] !== 32'h1234 || q_phase[0] !== 6'd0 || q_last[0] !== 1'b1) begin
            n_bad++; $display("FAIL single_result: got %0h/%0d/%b want 1234/0/1", q_data[0], q_phase[0], q_last[0]);
        end
        n_cmp++; if (done_cnt !== 1) begin
            n_bad++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_four_phase();
        bit ok;
        int bad_ph;
        logic [5:0] prev;
        clear_q();
        model_base = 32'd100; model_delay = 6;
        res_ready = 1'b1;
        do_start(6'd3, 8'd0);
        bad_ph = 0; prev = 6'd0; ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (phase < prev || phase > 6'd3) bad_ph++;
            prev = phase;
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        n_cmp++; if (!ok) begin
            n_bad++; $display("FAIL four_timeout: busy still 1 want 0");
        end
        n_cmp++; if (bad_ph !== 0) begin
            n_bad++; $display("FAIL four_phase_steps: got %0d bad cycles want 0", bad_ph);
        end
        n_cmp++; if (q_data.size() !== 4) begin
            n_bad++; $display("FAIL four_count: got %0d want 4", q_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (q_data[i] !== 32'(100 + i) || q_phase[i] !== 6'(i) || q_last[i] !== (i == 3)) begin
                n_bad++; $display("FAIL four_res%0d: got %0d/%0d/%b want %0d/%0d/%b",
                                  i, q_data[i], q_phase[i], q_last[i], 100 + i, i, (i == 3));
            end
        end
        n_cmp++; if (phase !== 6'd3 || done_cnt !== 1) begin
            n_bad++; $display("FAIL four_end: phase %0d done %0d want 3 1", phase, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad_v, bad_d, bad_s, bad_p;
        clear_q();
        model_base = 32'd200; model_delay = 3;
        res_ready = 1'b1;
        do_start(6'd2, 8'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (phase == 6'd1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        res_ready = 1'b0;
        for (int i = 0; i < 200 && ok; i++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        n_cmp++; if (!ok || res_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_reach: got valid %b want 1", res_valid);
        end
        bad_v = 0; bad_d = 0; bad_s = 0; bad_p = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b1) bad_v++;
            if (res_data !== 32'd201 || res_phase !== 6'd1 || res_last !== 1'b0) bad_d++;
            if (ets_start !== 1'b0) bad_s++;
            if (phase !== 6'd1) bad_p++;
            @(negedge clk);
        end
        n_cmp++; if (bad_v !== 0) begin n_bad++; $display("FAIL bp_valid: got %0d drops want 0", bad_v); end
        n_cmp++; if (bad_d !== 0) begin n_bad++; $display("FAIL bp_data: got %0d unstable want 0", bad_d); end
        n_cmp++; if (bad_s !== 0) begin n_bad++; $display("FAIL bp_start: got %0d high want 0", bad_s); end
        n_cmp++; if (bad_p !== 0) begin n_bad++; $display("FAIL bp_phase: got %0d advances want 0", bad_p); end
        res_ready = 1'b1;
        wait_done(300, ok);
        n_cmp++; if (!ok || q_data.size() !== 3 || q_data[1] !== 32'd201 || q_phase[1] !== 6'd1) begin
            n_bad++; $display("FAIL bp_results: got n=%0d d1=%0d want n=3 d1=201", q_data.size(), q_data[1]);
        end
    endtask

    task automatic test_enc();
        bit ok;
        int bad_e;
        clear_q();
        model_base = 32'd5; model_delay = 10;
        res_ready = 1'b1;
        n_cmp++; if (enc !== 1'b0) begin n_bad++; $display("FAIL enc_idle: got %b want 0", enc); end
        do_start(6'd0, 8'd3);
        bad_e = 0;
        for (int j = 0; j < 12; j++) begin
            if (enc !== ((j % 4) == 0)) bad_e++;
            @(negedge clk);
        end
        n_cmp++; if (bad_e !== 0) begin n_bad++; $display("FAIL enc_div3: got %0d wrong cycles want 0", bad_e); end
        wait_done(200, ok);
        n_cmp++; if (!ok || enc !== 1'b0) begin n_bad++; $display("FAIL enc_after: got %b want 0", enc); end
        do_start(6'd0, 8'd0);
        bad_e = 0;
        for (int j = 0; j < 12; j++) begin
            if (enc !== 1'b1) bad_e++;
            @(negedge clk);
        end
        n_cmp++; if (bad_e !== 0) begin n_bad++; $display("FAIL enc_div0: got %0d low cycles want 0", bad_e); end
        wait_done(200, ok);
    endtask

    task automatic test_sticky();
        bit ok;
        int bad_v;
        clear_q();
        model_base = 32'h55; model_delay = 4; model_sticky = 5;
        res_ready = 1'b1;
        do_start(6'd0, 8'd0);
        spur_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        spur_done = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || ets_start !== 1'b0) begin
            n_bad++; $display("FAIL spur_settle: got valid %b start %b want 0 0", res_valid, ets_start);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ets_start !== 1'b1) begin
            n_bad++; $display("FAIL spur_run: ets_start got %b want 1", ets_start);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ets_start) begin ok = 1'b1; break; end
        end
        bad_v = 0;
        for (int i = 0; i < 20 && ok; i++) begin
            if (!ets_done) break;
            if (res_valid !== 1'b0) bad_v++;
            @(negedge clk);
        end
        n_cmp++; if (!ok || bad_v !== 0 || ets_done !== 1'b0 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL sticky_hold: got %0d early valid, valid %b want 0 0", bad_v, res_valid);
        end
        @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin
            n_bad++; $display("FAIL sticky_rise: got %b want 1", res_valid);
        end
        wait_done(100, ok);
        n_cmp++; if (!ok || q_data.size() !== 1 || q_data[0] !== 32'h55) begin
            n_bad++; $display("FAIL sticky_single: got n=%0d d=%0h want n=1 d=55", q_data.size(), q_data[0]);
        end
        model_sticky = 0;
    endtask

    task automatic test_reset_restart();
        bit ok;
        clear_q();
        model_base = 32'd300; model_delay = 10;
        res_ready = 1'b1;
        do_start(6'd3, 8'd2);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (phase == 6'd2 && ets_start) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (!ok || {ets_start, busy, res_valid, enc, sweep_done, res_last} !== 6'b0) begin
            n_bad++; $display("FAIL rst_mid_ctl: got %b want 000000", {ets_start, busy, res_valid, enc, sweep_done, res_last});
        end
        n_cmp++; if (phase !== 6'd0 || res_phase !== 6'd0 || res_data !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid_data: got %0d/%0d/%0h want 0/0/0", phase, res_phase, res_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        do_start(6'd1, 8'd0);
        n_cmp++; if (busy !== 1'b1 || phase !== 6'd0) begin
            n_bad++; $display("FAIL restart: busy %b phase %0d want 1 0", busy, phase);
        end
        repeat (3) @(negedge clk);
        last_phase  = 6'd3;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        wait_done(300, ok);
        n_cmp++; if (!ok || q_data.size() !== 2 || q_phase[1] !== 6'd1 || q_last[1] !== 1'b1 || q_data[1] !== 32'd301) begin
            n_bad++; $display("FAIL ignored_start: got n=%0d p1=%0d l1=%b d1=%0d want 2/1/1/301",
                              q_data.size(), q_phase[1], q_last[1], q_data[1]);
        end
        n_cmp++; if (done_cnt !== 1) begin
            n_bad++; $display("FAIL restart_done: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_full_range();
        bit ok;
        clear_q();
        model_base = 32'd0; model_delay = 1;
        res_ready = 1'b1;
        do_start(6'd63, 8'd0);
        wait_done(3000, ok);
        n_cmp++; if (!ok || q_data.size() !== 64) begin
            n_bad++; $display("FAIL full_count: got %0d want 64", q_data.size());
        end
        n_cmp++; if (q_phase[63] !== 6'd63 || q_last[63] !== 1'b1 || q_last[62] !== 1'b0 || q_data[63] !== 32'd63) begin
            n_bad++; $display("FAIL full_last: got p=%0d l=%b l62=%b d=%0d want 63/1/0/63",
                              q_phase[63], q_last[63], q_last[62], q_data[63]);
        end
        n_cmp++; if (phase !== 6'd63 || done_cnt !== 1) begin
            n_bad++; $display("FAIL full_end: phase %0d done %0d want 63 1", phase, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_phase();
        test_four_phase();
        test_backpressure();
        test_enc();
        test_sticky();
        test_reset_restart();
        test_full_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
